lsb_ooo: RTL and testbench

Parametrised load/store buffer that sits between the decoder/dispatch stage, the ROB and the memory controller. It holds memory instructions in program order and wakes up their operands from two result buses. Stores issue only when they are the ROB head. A load may bypass older stores whose addresses are known to be on different words. Requests in flight are carried to completion across a flush, so the memory controller never sees an aborted transaction.

---
 rtl/lsb_ooo.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_lsb_ooo.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsb_ooo.sv
// lsb_ooo: load/store buffer between dispatch, the ROB and the memory controller.
//
// Memory instructions are held in program order in a circular queue. Each
// entry picks up its operands from the ALU bus (cdb_*) and from this block's
// own completion bus (out_*). One request is in flight at a time.
//   - The head entry issues first. A store waits until it is the ROB head.
//     A load to I/O space also waits until it is the ROB head.
//   - Otherwise, the oldest non-head load may bypass older stores. Each older
//     store must have a known address on a different 32-bit word.
//   - A flush empties the queue. A request that is already in flight is held
//     until mem_done, and then completes with no result pulse.
//
// Ports
//   clk_in, rst_in, rdy_in        clock, sync active-high reset, global stall
//   clear_flag                    mispredict flush
//   ins_*                         dispatch insert (op, tag, operands, imm)
//   lsb_full                      dispatch must not insert next cycle
//   cdb_valid/rob_id/val          ALU result bus used for wakeup
//   rob_head_valid/id             current ROB head (store / I/O gating)
//   mem_req/addr/wdata/op         request to the memory controller
//   mem_done/mem_rdata            completion pulse and load data
//   out_valid/rob_id/val/is_store completion bus (one-cycle pulse)
module lsb_ooo #(
    parameter int          DEPTH_BIT = 3,
    parameter int          ROB_BIT   = 5,
    parameter logic [31:0] IO_BASE   = 32'h0003_0000
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clear_flag,
    input  logic               ins_valid,
    input  logic [3:0]         ins_op,
    input  logic [ROB_BIT-1:0] ins_rob_id,
    input  logic [31:0]        ins_v1,
    input  logic [31:0]        ins_v2,
    input  logic               ins_q1_valid,
    input  logic               ins_q2_valid,
    input  logic [ROB_BIT-1:0] ins_q1,
    input  logic [ROB_BIT-1:0] ins_q2,
    input  logic [11:0]        ins_imm,
    output logic               lsb_full,
    input  logic               cdb_valid,
    input  logic [ROB_BIT-1:0] cdb_rob_id,
    input  logic [31:0]        cdb_val,
    input  logic               rob_head_valid,
    input  logic [ROB_BIT-1:0] rob_head_id,
    output logic               mem_req,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    output logic [3:0]         mem_op,
    input  logic               mem_done,
    input  logic [31:0]        mem_rdata,
    output logic               out_valid,
    output logic [ROB_BIT-1:0] out_rob_id,
    output logic [31:0]        out_val,
    output logic               out_is_store
);

    localparam int                 DEPTH    = 1 << DEPTH_BIT;
    localparam logic [DEPTH_BIT:0] FULL_CNT = (DEPTH_BIT+1)'(DEPTH);
    localparam logic [DEPTH_BIT:0] NEAR_CNT = FULL_CNT - 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;

    typedef struct packed {
        logic               valid;
        logic               issued;
        logic               done;
        logic [3:0]         op;
        logic [ROB_BIT-1:0] rob_id;
        logic [31:0]        v1;
        logic               q1v;
        logic [ROB_BIT-1:0] q1;
        logic [31:0]        v2;
        logic               q2v;
        logic [ROB_BIT-1:0] q2;
        logic [11:0]        imm;
    } entry_t;

    entry_t                 ent_q [DEPTH];
    entry_t                 ent_d [DEPTH];
    logic [DEPTH_BIT-1:0]   head_q, head_d, tail_q, tail_d, cur_q, cur_d;
    logic [DEPTH_BIT:0]     count_q, count_d;
    state_t                 state_q, state_d;
    logic                   mem_req_q, mem_req_d;
    logic [31:0]            mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]             mem_op_q, mem_op_d;
    logic                   out_valid_q, out_valid_d;
    logic [ROB_BIT-1:0]     out_rob_id_q, out_rob_id_d;
    logic [31:0]            out_val_q, out_val_d;
    logic                   out_is_store_q, out_is_store_d;

    // Issue selection signals (entries viewed in age order, offset 0 = head)
    logic [DEPTH_BIT-1:0]   ord_idx [DEPTH];
    logic [31:0]            ord_ea  [DEPTH];
    logic                   live    [DEPTH];
    logic                   head_ok, cand, issue_found;
    logic [DEPTH_BIT-1:0]   issue_idx;
    logic                   do_ins, do_retire;
    logic [32:0]            w1, w2;

    function automatic logic [31:0] calc_ea(input entry_t e);
        return e.v1 + {{20{e.imm[11]}}, e.imm};
    endfunction

    function automatic logic is_io(input logic [31:0] a);
        return a[31:16] == IO_BASE[31:16];
    endfunction

    function automatic logic rob_match(input logic [ROB_BIT-1:0] id);
        return rob_head_valid && (rob_head_id == id);
    endfunction

    // Returns {still_pending, value}. cdb wins over out when both match.
    function automatic logic [32:0] wake_op(input logic qv, input logic [ROB_BIT-1:0] q,
                                            input logic [31:0] v);
        if (qv && cdb_valid && cdb_rob_id == q)     return {1'b0, cdb_val};
        if (qv && out_valid_q && out_rob_id_q == q) return {1'b0, out_val_q};
        return {qv, v};
    endfunction

    assign lsb_full = (count_q == FULL_CNT) || (ins_valid && count_q == NEAR_CNT);

    // Issue selection: the head entry first, then the oldest load that can
    // safely bypass every older store.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latches are inferred.
        head_ok     = 1'b0;
        cand        = 1'b0;
        issue_found = 1'b0;
        issue_idx   = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            ord_idx[k] = head_q + DEPTH_BIT'(k);
            ord_ea[k]  = calc_ea(ent_q[ord_idx[k]]);
            live[k]    = (k < int'(count_q)) && ent_q[ord_idx[k]].valid;
        end

        if (live[0] && !ent_q[head_q].issued && !ent_q[head_q].done) begin
            if (ent_q[head_q].op[3])
                head_ok = !ent_q[head_q].q1v && !ent_q[head_q].q2v &&
                          rob_match(ent_q[head_q].rob_id);
            else
                head_ok = !ent_q[head_q].q1v &&
                          (!is_io(ord_ea[0]) || rob_match(ent_q[head_q].rob_id));
        end
        if (head_ok) begin
            issue_found = 1'b1;
            issue_idx   = head_q;
        end

        for (int j = 1; j < DEPTH; j++) begin
            cand = live[j] && !ent_q[ord_idx[j]].op[3] && !ent_q[ord_idx[j]].issued &&
                   !ent_q[ord_idx[j]].done && !ent_q[ord_idx[j]].q1v && !is_io(ord_ea[j]);
            // A store with an unknown base, or one that writes the same word, blocks the load.
            for (int i = 0; i < j; i++) begin
                if (ent_q[ord_idx[i]].op[3] &&
                    (ent_q[ord_idx[i]].q1v || ord_ea[i][31:2] == ord_ea[j][31:2]))
                    cand = 1'b0;
            end
            if (cand && !issue_found) begin
                issue_found = 1'b1;
                issue_idx   = ord_idx[j];
            end
        end
    end

    // Next state: wakeup, FSM, retire, insert, then flush overrides the queue.
    always_comb begin
        ent_d          = ent_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        cur_d          = cur_q;
        state_d        = state_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_op_d       = mem_op_q;
        out_valid_d    = 1'b0;
        out_rob_id_d   = out_rob_id_q;
        out_val_d      = out_val_q;
        out_is_store_d = out_is_store_q;
        do_ins         = 1'b0;
        do_retire      = 1'b0;
        w1             = '0;
        w2             = '0;

        for (int k = 0; k < DEPTH; k++) begin
            if (ent_q[k].valid) begin
                w1 = wake_op(ent_q[k].q1v, ent_q[k].q1, ent_q[k].v1);
                w2 = wake_op(ent_q[k].q2v, ent_q[k].q2, ent_q[k].v2);
                ent_d[k].q1v = w1[32];
                ent_d[k].v1  = w1[31:0];
                ent_d[k].q2v = w2[32];
                ent_d[k].v2  = w2[31:0];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (issue_found && !clear_flag) begin
                    state_d                  = S_BUSY;
                    cur_d                    = issue_idx;
                    ent_d[issue_idx].issued  = 1'b1;
                    mem_req_d                = 1'b1;
                    mem_addr_d               = calc_ea(ent_q[issue_idx]);
                    mem_wdata_d              = ent_q[issue_idx].v2;
                    mem_op_d                 = ent_q[issue_idx].op;
                end
            end
            S_BUSY: begin
                if (mem_done) begin
                    state_d           = S_IDLE;
                    mem_req_d         = 1'b0;
                    ent_d[cur_q].done = 1'b1;
                    out_valid_d       = 1'b1;
                    out_rob_id_d      = ent_q[cur_q].rob_id;
                    out_is_store_d    = ent_q[cur_q].op[3];
                    out_val_d         = ent_q[cur_q].op[3] ? 32'h0 : mem_rdata;
                end else if (clear_flag) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mem_done) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (count_q != '0 && ent_q[head_q].valid && ent_q[head_q].done) begin
            do_retire            = 1'b1;
            ent_d[head_q].valid  = 1'b0;
            head_d               = head_q + 1'b1;
        end

        if (ins_valid && count_q != FULL_CNT) begin
            do_ins                 = 1'b1;
            w1                     = wake_op(ins_q1_valid, ins_q1, ins_v1);
            w2                     = wake_op(ins_q2_valid, ins_q2, ins_v2);
            ent_d[tail_q].valid    = 1'b1;
            ent_d[tail_q].issued   = 1'b0;
            ent_d[tail_q].done     = 1'b0;
            ent_d[tail_q].op       = ins_op;
            ent_d[tail_q].rob_id   = ins_rob_id;
            ent_d[tail_q].q1v      = w1[32];
            ent_d[tail_q].v1       = w1[31:0];
            ent_d[tail_q].q1       = ins_q1;
            ent_d[tail_q].q2v      = w2[32];
            ent_d[tail_q].v2       = w2[31:0];
            ent_d[tail_q].q2       = ins_q2;
            ent_d[tail_q].imm      = ins_imm;
            tail_d                 = tail_q + 1'b1;
        end

        count_d = count_q + (DEPTH_BIT+1)'(do_ins) - (DEPTH_BIT+1)'(do_retire);

        // The in-flight request and its FSM state survive the flush.
        if (clear_flag) begin
            ent_d       = '{default: '0};
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: the queue is small, so all of it is reset. This keeps X out of the wakeup and issue compares.
            ent_q          <= '{default: '0};
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            cur_q          <= '0;
            state_q        <= S_IDLE;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_op_q       <= '0;
            out_valid_q    <= 1'b0;
            out_rob_id_q   <= '0;
            out_val_q      <= '0;
            out_is_store_q <= 1'b0;
        end else if (rdy_in) begin
            // NOTE: non-blocking assignments, so every register samples the pre-edge values.
            ent_q          <= ent_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            cur_q          <= cur_d;
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_op_q       <= mem_op_d;
            out_valid_q    <= out_valid_d;
            out_rob_id_q   <= out_rob_id_d;
            out_val_q      <= out_val_d;
            out_is_store_q <= out_is_store_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_op       = mem_op_q;
    assign out_valid    = out_valid_q;
    assign out_rob_id   = out_rob_id_q;
    assign out_val      = out_val_q;
    assign out_is_store = out_is_store_q;

endmodule

// File: tb/tb_lsb_ooo.sv
// tb_lsb_ooo: directed self-checking bench for lsb_ooo. Expected memory
// requests and completion results go into scoreboard queues when the
// stimulus is driven. They are popped and compared when the DUT produces them.
module tb_lsb_ooo;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_flag, ins_valid;
    logic [3:0]  ins_op;
    logic [4:0]  ins_rob_id, ins_q1, ins_q2;
    logic [31:0] ins_v1, ins_v2;
    logic        ins_q1_valid, ins_q2_valid;
    logic [11:0] ins_imm;
    logic        lsb_full;
    logic        cdb_valid;
    logic [4:0]  cdb_rob_id;
    logic [31:0] cdb_val;
    logic        rob_head_valid;
    logic [4:0]  rob_head_id;
    logic        mem_req;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_op;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [4:0]  out_rob_id;
    logic [31:0] out_val;
    logic        out_is_store;

    always #5 clk_in = ~clk_in;

    lsb_ooo #(.DEPTH_BIT(3), .ROB_BIT(5), .IO_BASE(32'h0003_0000)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
        .ins_valid(ins_valid), .ins_op(ins_op), .ins_rob_id(ins_rob_id),
        .ins_v1(ins_v1), .ins_v2(ins_v2), .ins_q1_valid(ins_q1_valid),
        .ins_q2_valid(ins_q2_valid), .ins_q1(ins_q1), .ins_q2(ins_q2),
        .ins_imm(ins_imm), .lsb_full(lsb_full), .cdb_valid(cdb_valid),
        .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val), .rob_head_valid(rob_head_valid),
        .rob_head_id(rob_head_id), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_op(mem_op), .mem_done(mem_done),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_rob_id(out_rob_id),
        .out_val(out_val), .out_is_store(out_is_store)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  op;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [4:0]  id;
        logic [31:0] val;
        logic        st;
    } res_t;

    req_t exp_req[$];
    res_t exp_res[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [3:0] OP_LW = 4'b0010;
    localparam logic [3:0] OP_SW = 4'b1010;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge. Outputs are then sampled and inputs driven 1 time unit later.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic insert(input logic st, input logic [4:0] tag, input logic [31:0] v1,
                          input logic [11:0] imm, input logic [31:0] v2,
                          input logic q1v, input logic [4:0] q1);
        ins_valid    = 1'b1;
        ins_op       = st ? OP_SW : OP_LW;
        ins_rob_id   = tag;
        ins_v1       = v1;
        ins_imm      = imm;
        ins_v2       = v2;
        ins_q1_valid = q1v;
        ins_q1       = q1;
        ins_q2_valid = 1'b0;
        ins_q2       = '0;
        step();
        ins_valid    = 1'b0;
    endtask

    task automatic push_req(input logic [31:0] addr, input logic [3:0] op, input logic [31:0] wd);
        req_t r;
        r.addr = addr; r.op = op; r.wdata = wd;
        exp_req.push_back(r);
    endtask

    task automatic push_res(input logic [4:0] id, input logic [31:0] val, input logic st);
        res_t e;
        e.id = id; e.val = val; e.st = st;
        exp_res.push_back(e);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (mem_req !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check({tag, "_req_seen"}, {31'b0, mem_req}, 32'd1);
    endtask

    // Serve one memory request and compare it with the scoreboard. When
    // expect_out is set, also check the result pulse that follows.
    task automatic serve(input string tag, input logic [31:0] rdata, input bit expect_out);
        req_t r;
        res_t e;
        wait_req(tag);
        check({tag, "_req_queued"}, {31'b0, exp_req.size() != 0}, 32'd1);
        if (exp_req.size() != 0) begin
            r = exp_req.pop_front();
            check({tag, "_addr"}, mem_addr, r.addr);
            check({tag, "_op"}, {28'b0, mem_op}, {28'b0, r.op});
            if (r.op[3]) check({tag, "_wdata"}, mem_wdata, r.wdata);
            step();
            check({tag, "_req_held"}, {31'b0, mem_req}, 32'd1);
            check({tag, "_addr_held"}, mem_addr, r.addr);
        end
        mem_done  = 1'b1;
        mem_rdata = rdata;
        step();
        mem_done  = 1'b0;
        mem_rdata = '0;
        check({tag, "_req_fall"}, {31'b0, mem_req}, 32'd0);
        if (expect_out) begin
            check({tag, "_res_queued"}, {31'b0, exp_res.size() != 0}, 32'd1);
            if (exp_res.size() != 0) begin
                e = exp_res.pop_front();
                check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
                check({tag, "_out_id"}, {27'b0, out_rob_id}, {27'b0, e.id});
                check({tag, "_out_val"}, out_val, e.val);
                check({tag, "_out_st"}, {31'b0, out_is_store}, {31'b0, e.st});
            end
        end else begin
            check({tag, "_no_out"}, {31'b0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_flag = 1'b0; ins_valid = 1'b0;
        ins_op = '0; ins_rob_id = '0; ins_v1 = '0; ins_v2 = '0; ins_imm = '0;
        ins_q1_valid = 1'b0; ins_q2_valid = 1'b0; ins_q1 = '0; ins_q2 = '0;
        cdb_valid = 1'b0; cdb_rob_id = '0; cdb_val = '0;
        rob_head_valid = 1'b0; rob_head_id = '0;
        mem_done = 1'b0; mem_rdata = '0;
        repeat (2) step();
        rst_in = 1'b0;

        // Reset values
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_op", {28'b0, mem_op}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_rob_id", {27'b0, out_rob_id}, 32'd0);
        check("rst_out_val", out_val, 32'd0);
        check("rst_out_is_store", {31'b0, out_is_store}, 32'd0);
        check("rst_lsb_full", {31'b0, lsb_full}, 32'd0);

        // 1: lw 0x100+4 issues at cycle 2 without being the ROB head
        insert(1'b0, 5'd1, 32'h100, 12'd4, 32'h0, 1'b0, 5'd0);
        check("s1_no_req_cycle1", {31'b0, mem_req}, 32'd0);
        step();
        check("s1_req_cycle2", {31'b0, mem_req}, 32'd1);
        push_req(32'h104, OP_LW, 32'h0);
        push_res(5'd1, 32'hDEAD, 1'b0);
        serve("s1", 32'hDEAD, 1'b1);
        step();
        check("s1_out_pulse_one", {31'b0, out_valid}, 32'd0);

        // 2: a younger load bypasses a store to a different word; the store waits for ROB head
        insert(1'b1, 5'd3, 32'h200, 12'd0, 32'h1234, 1'b0, 5'd0);
        insert(1'b0, 5'd4, 32'h300, 12'd0, 32'h0, 1'b0, 5'd0);
        push_req(32'h300, OP_LW, 32'h0);
        push_res(5'd4, 32'h55, 1'b0);
        serve("s2_ld", 32'h55, 1'b1);
        repeat (3) step();
        check("s2_st_waits", {31'b0, mem_req}, 32'd0);
        rob_head_valid = 1'b1; rob_head_id = 5'd3;
        push_req(32'h200, OP_SW, 32'h1234);
        push_res(5'd3, 32'h0, 1'b1);
        serve("s2_st", 32'hFFFF_FFFF, 1'b1);
        rob_head_valid = 1'b0;
        repeat (3) step();

        // 3: a store with a pending base blocks the load; after wakeup, same word still blocks
        insert(1'b1, 5'd5, 32'h0, 12'd0, 32'h77, 1'b1, 5'd9);
        insert(1'b0, 5'd6, 32'h200, 12'd0, 32'h0, 1'b0, 5'd0);
        repeat (3) step();
        check("s3_unknown_base", {31'b0, mem_req}, 32'd0);
        cdb_valid = 1'b1; cdb_rob_id = 5'd9; cdb_val = 32'h200;
        step();
        cdb_valid = 1'b0;
        repeat (3) step();
        check("s3_same_word", {31'b0, mem_req}, 32'd0);
        rob_head_valid = 1'b1; rob_head_id = 5'd5;
        push_req(32'h200, OP_SW, 32'h77);
        push_res(5'd5, 32'h0, 1'b1);
        serve("s3_st", 32'h0, 1'b1);
        rob_head_valid = 1'b0;
        push_req(32'h200, OP_LW, 32'h0);
        push_res(5'd6, 32'hABCD, 1'b0);
        serve("s3_ld", 32'hABCD, 1'b1);
        repeat (3) step();

        // 4: I/O load (0x30008 - 4) waits for the ROB head
        insert(1'b0, 5'd7, 32'h0003_0008, 12'hFFC, 32'h0, 1'b0, 5'd0);
        repeat (3) step();
        check("s4_io_waits", {31'b0, mem_req}, 32'd0);
        rob_head_valid = 1'b1; rob_head_id = 5'd7;
        push_req(32'h0003_0004, OP_LW, 32'h0);
        push_res(5'd7, 32'h99, 1'b0);
        serve("s4", 32'h99, 1'b1);
        rob_head_valid = 1'b0;
        repeat (3) step();

        // 5: fill the queue with stores, then retire one, then insert with cdb capture
        for (int i = 0; i < 8; i++) begin
            ins_valid    = 1'b1;
            ins_op       = OP_SW;
            ins_rob_id   = 5'(10 + i);
            ins_v1       = 32'h1000 + 32'(16 * i);
            ins_imm      = '0;
            ins_v2       = 32'(i);
            ins_q1_valid = 1'b0;
            ins_q1       = '0;
            #1;
            if (i == 7) check("s5_full_near", {31'b0, lsb_full}, 32'd1);
            step();
        end
        ins_valid = 1'b0;
        #1;
        check("s5_full", {31'b0, lsb_full}, 32'd1);
        rob_head_valid = 1'b1; rob_head_id = 5'd10;
        push_req(32'h1000, OP_SW, 32'h0);
        push_res(5'd10, 32'h0, 1'b1);
        serve("s5_st", 32'h0, 1'b1);
        rob_head_valid = 1'b0;
        step();
        check("s5_not_full", {31'b0, lsb_full}, 32'd0);
        cdb_valid = 1'b1; cdb_rob_id = 5'd12; cdb_val = 32'h400;
        insert(1'b0, 5'd20, 32'hDEAD_0000, 12'd0, 32'h0, 1'b1, 5'd12);
        cdb_valid = 1'b0;
        check("s5_refull", {31'b0, lsb_full}, 32'd1);
        push_req(32'h400, OP_LW, 32'h0);
        push_res(5'd20, 32'h4444, 1'b0);
        serve("s5_cap", 32'h4444, 1'b1);

        // 6: flush while a store is in flight; the insert in the flush cycle is ignored
        rob_head_valid = 1'b1; rob_head_id = 5'd11;
        wait_req("s6");
        check("s6_addr", mem_addr, 32'h1010);
        rob_head_valid = 1'b0;
        clear_flag   = 1'b1;
        ins_valid    = 1'b1;
        ins_op       = OP_LW;
        ins_rob_id   = 5'd25;
        ins_v1       = 32'h500;
        ins_imm      = '0;
        ins_q1_valid = 1'b0;
        step();
        clear_flag = 1'b0;
        ins_valid  = 1'b0;
        check("s6_req_held", {31'b0, mem_req}, 32'd1);
        check("s6_addr_held", mem_addr, 32'h1010);
        step();
        check("s6_not_full", {31'b0, lsb_full}, 32'd0);
        push_req(32'h1010, OP_SW, 32'h1);
        serve("s6", 32'h0, 1'b0);
        repeat (4) step();
        check("s6_idle_after", {31'b0, mem_req}, 32'd0);
        check("s6_no_pulse", {31'b0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
